ysyx_23060077_riscv_axi_master: RTL and testbench
=================================================

YSYX_23060077_RISCV_AXI_MASTER -- requirements
Module: ysyx_23060077_riscv_axi_master
Interface
REQ-001 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port areset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port req_valid_i  input  1  core request valid.
REQ-004 SHALL have port req_ready_o  output  1  core request accepted when high with req_valid_i.
REQ-005 SHALL have port req_wen_i  input  1  1=write, 0=read.
REQ-006 SHALL have port req_addr_i  input  32  byte address.
REQ-007 SHALL have port req_wdata_i  input  32  write data.
REQ-008 SHALL have port req_wstrb_i  input  4  write byte strobes.
REQ-009 SHALL have port rsp_valid_o  output  1  one-cycle response pulse.
REQ-010 SHALL have port rsp_rdata_o  output  32  read data, 0 for writes.
REQ-011 SHALL have port rsp_err_o  output  1  1 = response error.
REQ-012 SHALL have port axi_aw_ready_i  input  1  write-address ready.
REQ-013 SHALL have port axi_aw_valid_o  output  1  write-address valid.
REQ-014 SHALL have port axi_aw_port_o  output  3  protection, constant 3'b000.
REQ-015 SHALL have port axi_aw_addr_o  output  32  write address.
REQ-016 SHALL have port axi_w_ready_i  input  1  write-data ready.
REQ-017 SHALL have port axi_w_valid_o  output  1  write-data valid.
REQ-018 SHALL have port axi_w_strb_i  output  4  write strobes (named axi_w_strb_o).
REQ-019 SHALL have port axi_w_data_o  output  32  write data.
REQ-020 SHALL have port axi_b_resp_i  input  2  write response.
REQ-021 SHALL have port axi_b_valid_i  input  1  write response valid.
REQ-022 SHALL have port axi_b_ready_o  output  1  write response ready.
REQ-023 SHALL have port axi_ar_ready_i  input  1  read-address ready.
REQ-024 SHALL have port axi_ar_valid_o  output  1  read-address valid.
REQ-025 SHALL have port axi_ar_port_o  output  3  protection, constant 3'b000.
REQ-026 SHALL have port axi_ar_addr_o  output  32  read address.
REQ-027 SHALL have port axi_r_ready_o  output  1  read data ready.
REQ-028 SHALL have ports axi_r_valid_i (1), axi_r_resp_i (2), axi_r_data_i (32), all inputs: read data channel.
Function
REQ-029 SHALL implement FSM IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP; one outstanding transaction; req_ready_o=1 only in IDLE; req_* ignored elsewhere.
REQ-030 SHALL on req handshake latch addr/wdata/wstrb and go to RD_ADDR (wen=0) or WR_REQ (wen=1); AXI address/data outputs held stable from latch until transaction end.
REQ-031 SHALL in RD_ADDR drive axi_ar_valid_o=1 until axi_ar_ready_i sampled high, then RD_DATA; in RD_DATA drive axi_r_ready_o=1, on axi_r_valid_i capture data, err=(axi_r_resp_i!=0), go RESP.
REQ-032 SHALL in WR_REQ assert axi_aw_valid_o and axi_w_valid_o together; each drops the cycle after its own handshake (aw_done/w_done flags); same-cycle handshakes legal; go WR_RESP when both done.
REQ-033 SHALL in WR_RESP drive axi_b_ready_o=1; on axi_b_valid_i set err=(axi_b_resp_i!=0), rdata=0, go RESP.
REQ-034 SHALL in RESP assert rsp_valid_o exactly one cycle, then IDLE; rsp_rdata_o/rsp_err_o held until next response.
REQ-035 SHALL never withdraw a valid before handshake; all outputs from registers/state, no combinational input-to-output path.
REQ-036 SHALL give latency N+3 for zero-wait slave: accept N, AR/AW+W handshake N+1, R/B handshake N+2, rsp_valid_o N+3.
Reset
REQ-037 SHALL on areset_n=0 at clock edge go IDLE, clear flags, drive all valid/ready outputs 0, rsp_rdata_o=0, rsp_err_o=0, abandoning any in-flight transaction.
Configuration
REQ-038 SHALL with YSYX_23060077_AXI_TIMEOUT_EN defined count cycles (8-bit, cleared on state change) in RD_ADDR/RD_DATA/WR_REQ/WR_RESP; at 255 drop all valids/readies, go RESP with rsp_err_o=1, rsp_rdata_o=0.
REQ-039 SHALL without YSYX_23060077_AXI_TIMEOUT_EN omit the counter and wait indefinitely.
Verification
REQ-040 SHALL cover: read 0x80000004, slave zero-wait, r_data=0xDEADBEEF resp=0 -> rsp_valid_o at N+3, rdata 0xDEADBEEF, err 0.
REQ-041 SHALL cover: write 0x80000010 data 0x12345678 strb 4'b0011, w_ready 3 cycles after aw_ready -> aw_valid drops early, w_valid held, one B, rsp err 0.
REQ-042 SHALL cover: read with axi_r_resp_i=2'b10 -> rsp_err_o=1 for that response.
REQ-043 SHALL cover: areset_n=0 during RD_DATA -> next cycle all valids 0, req_ready_o=1 after release, no rsp_valid_o.
REQ-044 SHALL cover: with TIMEOUT_EN, ar_ready held 0 -> rsp_valid_o with rsp_err_o=1 after 255 wait cycles; without, no response.

Source files
------------

// File: rtl/ysyx_23060077_riscv_axi_master.sv
// Core-to-AXI4-Lite bridge: one outstanding read or write, single-beat transfers.
// Latency: request accepted in cycle N, rsp_valid_o in cycle N+3 with a zero-wait slave.
// Backpressure: req_ready_o only in IDLE; AXI valids are held until their handshake.
// Optional build macro: YSYX_23060077_AXI_TIMEOUT_EN aborts a transaction after 255 wait cycles.
module ysyx_23060077_riscv_axi_master (
   input  logic        aclk,
   input  logic        areset_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wen_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   input  logic        axi_aw_ready_i,
   output logic        axi_aw_valid_o,
   output logic [2:0]  axi_aw_port_o,
   output logic [31:0] axi_aw_addr_o,
   input  logic        axi_w_ready_i,
   output logic        axi_w_valid_o,
   output logic [3:0]  axi_w_strb_o,
   output logic [31:0] axi_w_data_o,
   input  logic [1:0]  axi_b_resp_i,
   input  logic        axi_b_valid_i,
   output logic        axi_b_ready_o,
   input  logic        axi_ar_ready_i,
   output logic        axi_ar_valid_o,
   output logic [2:0]  axi_ar_port_o,
   output logic [31:0] axi_ar_addr_o,
   output logic        axi_r_ready_o,
   input  logic        axi_r_valid_i,
   input  logic [1:0]  axi_r_resp_i,
   input  logic [31:0] axi_r_data_i
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_e;

   state_e      state_q;
   logic        req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;
   logic        ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
   logic        aw_done_q, w_done_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;

   logic        aw_hs, w_hs, wr_done, tmo_hit;

   assign aw_hs   = aw_valid_q & axi_aw_ready_i;
   assign w_hs    = w_valid_q & axi_w_ready_i;
   // both write channels finished, counting a handshake landing this cycle
   assign wr_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

`ifdef YSYX_23060077_AXI_TIMEOUT_EN
   logic [7:0] tmo_q;
   logic       in_wait, leave_wait;

   // identify the states that wait on the slave and the cycles that leave them normally
   always_comb begin
      in_wait    = 1'b0;
      leave_wait = 1'b0;
      case (state_q)
         RD_ADDR: begin in_wait = 1'b1; leave_wait = axi_ar_ready_i;  end
         RD_DATA: begin in_wait = 1'b1; leave_wait = axi_r_valid_i;   end
         WR_REQ:  begin in_wait = 1'b1; leave_wait = wr_done;         end
         WR_RESP: begin in_wait = 1'b1; leave_wait = axi_b_valid_i;   end
         default: begin in_wait = 1'b0; leave_wait = 1'b0;            end
      endcase
   end

   // a handshake on the final cycle wins over the timeout so the slave never sees a lost transfer
   assign tmo_hit = in_wait && !leave_wait && (tmo_q == 8'hFF);

   // wait-cycle counter, restarted on every state change
   always_ff @(posedge aclk) begin
      if (!areset_n || !in_wait || leave_wait || tmo_hit) tmo_q <= 8'd0;
      else                                                tmo_q <= tmo_q + 8'd1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // transaction sequencer; every interface output is a register written here
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'd0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         wstrb_q     <= 4'd0;
      end else if (tmo_hit) begin
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         b_ready_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= 1'b1;
         rsp_err_q   <= 1'b1;
         rsp_rdata_q <= 32'd0;
         state_q     <= RESP;
      end else begin
         case (state_q)
            IDLE: begin
               req_ready_q <= 1'b1;
               if (req_valid_i && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  addr_q      <= req_addr_i;
                  wdata_q     <= req_wdata_i;
                  wstrb_q     <= req_wstrb_i;
                  if (req_wen_i) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= WR_REQ;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= RD_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (axi_ar_ready_i) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (axi_r_valid_i) begin
                  r_ready_q   <= 1'b0;
                  rsp_rdata_q <= axi_r_data_i;
                  rsp_err_q   <= (axi_r_resp_i != 2'b00);
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
                  w_done_q  <= 1'b1;
               end
               if (wr_done) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  b_ready_q <= 1'b1;
                  state_q   <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (axi_b_valid_i) begin
                  b_ready_q   <= 1'b0;
                  rsp_rdata_q <= 32'd0;
                  rsp_err_q   <= (axi_b_resp_i != 2'b00);
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o    = req_ready_q;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_rdata_o    = rsp_rdata_q;
   assign rsp_err_o      = rsp_err_q;
   assign axi_aw_valid_o = aw_valid_q;
   assign axi_aw_port_o  = 3'b000;
   assign axi_aw_addr_o  = addr_q;
   assign axi_w_valid_o  = w_valid_q;
   assign axi_w_strb_o   = wstrb_q;
   assign axi_w_data_o   = wdata_q;
   assign axi_b_ready_o  = b_ready_q;
   assign axi_ar_valid_o = ar_valid_q;
   assign axi_ar_port_o  = 3'b000;
   assign axi_ar_addr_o  = addr_q;
   assign axi_r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_ysyx_23060077_riscv_axi_master.sv
// Directed bench for the AXI master bridge: reads, writes, error responses, reset abort, timeout.
// Inputs change 1 ns after the rising edge; outputs are checked in that same window.
// Slave behaviour is scripted cycle by cycle inside one initial block.
module tb_ysyx_23060077_riscv_axi_master;

   logic        aclk, areset_n;
   logic        req_valid_i, req_ready_o, req_wen_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic [3:0]  req_wstrb_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        axi_aw_ready_i, axi_aw_valid_o;
   logic [2:0]  axi_aw_port_o, axi_ar_port_o;
   logic [31:0] axi_aw_addr_o, axi_w_data_o, axi_ar_addr_o, axi_r_data_i;
   logic        axi_w_ready_i, axi_w_valid_o;
   logic [3:0]  axi_w_strb_o;
   logic [1:0]  axi_b_resp_i, axi_r_resp_i;
   logic        axi_b_valid_i, axi_b_ready_o;
   logic        axi_ar_ready_i, axi_ar_valid_o, axi_r_ready_o, axi_r_valid_i;

   int errors = 0;
   int checks = 0;

   ysyx_23060077_riscv_axi_master dut (
      .aclk(aclk), .areset_n(areset_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .axi_aw_ready_i(axi_aw_ready_i), .axi_aw_valid_o(axi_aw_valid_o),
      .axi_aw_port_o(axi_aw_port_o), .axi_aw_addr_o(axi_aw_addr_o),
      .axi_w_ready_i(axi_w_ready_i), .axi_w_valid_o(axi_w_valid_o),
      .axi_w_strb_o(axi_w_strb_o), .axi_w_data_o(axi_w_data_o),
      .axi_b_resp_i(axi_b_resp_i), .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
      .axi_ar_ready_i(axi_ar_ready_i), .axi_ar_valid_o(axi_ar_valid_o),
      .axi_ar_port_o(axi_ar_port_o), .axi_ar_addr_o(axi_ar_addr_o),
      .axi_r_ready_o(axi_r_ready_o), .axi_r_valid_i(axi_r_valid_i),
      .axi_r_resp_i(axi_r_resp_i), .axi_r_data_i(axi_r_data_i)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb);
      req_valid_i = 1'b1;
      req_wen_i   = wen;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_wstrb_i = strb;
   endtask

   initial begin
      int pulses;
      int first_rsp;
      logic first_err;
      logic [31:0] first_rdata;

      areset_n = 1'b0;
      req_valid_i = 1'b0; req_wen_i = 1'b0; req_addr_i = 32'd0; req_wdata_i = 32'd0; req_wstrb_i = 4'd0;
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_b_valid_i = 1'b0; axi_b_resp_i = 2'b00;
      axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; axi_r_resp_i = 2'b00; axi_r_data_i = 32'd0;

      // reset state
      tick(); tick();
      chk("rst_ar_valid", axi_ar_valid_o, 0);
      chk("rst_aw_valid", axi_aw_valid_o, 0);
      chk("rst_w_valid", axi_w_valid_o, 0);
      chk("rst_r_ready", axi_r_ready_o, 0);
      chk("rst_b_ready", axi_b_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_rdata", rsp_rdata_o, 0);
      chk("rst_rsp_err", rsp_err_o, 0);
      areset_n = 1'b1;
      tick();
      chk("rst_req_ready", req_ready_o, 1);

      // zero-wait read of 0x80000004
      issue(1'b0, 32'h8000_0004, 32'd0, 4'd0);
      axi_ar_ready_i = 1'b1; axi_r_valid_i = 1'b1; axi_r_data_i = 32'hDEAD_BEEF; axi_r_resp_i = 2'b00;
      chk("rd_req_ready", req_ready_o, 1);
      tick();                                   // cycle N+1
      req_valid_i = 1'b0;
      chk("rd_ar_valid", axi_ar_valid_o, 1);
      chk("rd_ar_addr", axi_ar_addr_o, 32'h8000_0004);
      chk("rd_ar_port", axi_ar_port_o, 0);
      chk("rd_busy_ready", req_ready_o, 0);
      tick();                                   // cycle N+2
      chk("rd_ar_drop", axi_ar_valid_o, 0);
      chk("rd_r_ready", axi_r_ready_o, 1);
      chk("rd_no_rsp_yet", rsp_valid_o, 0);
      tick();                                   // cycle N+3
      chk("rd_rsp_valid", rsp_valid_o, 1);
      chk("rd_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("rd_rsp_err", rsp_err_o, 0);
      chk("rd_r_ready_drop", axi_r_ready_o, 0);
      axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0;
      tick();
      chk("rd_rsp_pulse", rsp_valid_o, 0);
      chk("rd_rdata_hold", rsp_rdata_o, 32'hDEAD_BEEF);
      chk("rd_idle_ready", req_ready_o, 1);

      // write with w_ready three cycles after aw_ready
      issue(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
      axi_aw_ready_i = 1'b1;
      tick();                                   // cycle N+1
      req_valid_i = 1'b0;
      chk("wr_aw_valid", axi_aw_valid_o, 1);
      chk("wr_w_valid", axi_w_valid_o, 1);
      chk("wr_aw_addr", axi_aw_addr_o, 32'h8000_0010);
      chk("wr_w_data", axi_w_data_o, 32'h1234_5678);
      chk("wr_w_strb", axi_w_strb_o, 4'b0011);
      chk("wr_aw_port", axi_aw_port_o, 0);
      tick();                                   // cycle N+2
      axi_aw_ready_i = 1'b0;
      chk("wr_aw_drop", axi_aw_valid_o, 0);
      chk("wr_w_hold1", axi_w_valid_o, 1);
      tick();                                   // cycle N+3
      chk("wr_w_hold2", axi_w_valid_o, 1);
      chk("wr_b_wait", axi_b_ready_o, 0);
      tick();                                   // cycle N+4
      chk("wr_w_hold3", axi_w_valid_o, 1);
      chk("wr_w_data_hold", axi_w_data_o, 32'h1234_5678);
      axi_w_ready_i = 1'b1;
      tick();                                   // cycle N+5
      axi_w_ready_i = 1'b0;
      chk("wr_w_drop", axi_w_valid_o, 0);
      chk("wr_b_ready", axi_b_ready_o, 1);
      chk("wr_no_rsp_yet", rsp_valid_o, 0);
      axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b00;
      tick();                                   // cycle N+6
      axi_b_valid_i = 1'b0;
      chk("wr_rsp_valid", rsp_valid_o, 1);
      chk("wr_rsp_err", rsp_err_o, 0);
      chk("wr_rsp_rdata", rsp_rdata_o, 0);
      chk("wr_b_ready_drop", axi_b_ready_o, 0);
      tick();
      chk("wr_rsp_pulse", rsp_valid_o, 0);

      // write with same-cycle AW/W handshakes and SLVERR on B
      issue(1'b1, 32'h8000_0020, 32'hCAFE_0001, 4'b1111);
      axi_aw_ready_i = 1'b1; axi_w_ready_i = 1'b1; axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b11;
      tick();                                   // cycle N+1
      req_valid_i = 1'b0;
      chk("wr2_both_valid", {axi_aw_valid_o, axi_w_valid_o}, 2'b11);
      tick();                                   // cycle N+2
      chk("wr2_both_drop", {axi_aw_valid_o, axi_w_valid_o}, 2'b00);
      chk("wr2_b_ready", axi_b_ready_o, 1);
      tick();                                   // cycle N+3
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_b_valid_i = 1'b0; axi_b_resp_i = 2'b00;
      chk("wr2_rsp_valid", rsp_valid_o, 1);
      chk("wr2_rsp_err", rsp_err_o, 1);
      chk("wr2_rsp_rdata", rsp_rdata_o, 0);
      tick();

      // read with SLVERR response
      issue(1'b0, 32'h8000_0008, 32'd0, 4'd0);
      axi_ar_ready_i = 1'b1; axi_r_valid_i = 1'b1; axi_r_data_i = 32'h1111_2222; axi_r_resp_i = 2'b10;
      tick();
      req_valid_i = 1'b0;
      tick(); tick();                           // cycle N+3
      chk("rderr_rsp_valid", rsp_valid_o, 1);
      chk("rderr_rsp_err", rsp_err_o, 1);
      chk("rderr_rsp_rdata", rsp_rdata_o, 32'h1111_2222);
      axi_ar_ready_i = 1'b0; axi_r_valid_i = 1'b0; axi_r_resp_i = 2'b00;
      tick();

      // reset asserted while waiting in RD_DATA
      issue(1'b0, 32'h8000_000C, 32'd0, 4'd0);
      axi_ar_ready_i = 1'b1;
      tick();
      req_valid_i = 1'b0;
      tick();                                   // cycle N+2, in RD_DATA
      axi_ar_ready_i = 1'b0;
      chk("rst_mid_r_ready", axi_r_ready_o, 1);
      areset_n = 1'b0;
      tick();
      chk("rst_mid_r_drop", axi_r_ready_o, 0);
      chk("rst_mid_ar_valid", axi_ar_valid_o, 0);
      chk("rst_mid_rsp_valid", rsp_valid_o, 0);
      chk("rst_mid_rsp_err", rsp_err_o, 0);
      chk("rst_mid_rsp_rdata", rsp_rdata_o, 0);
      areset_n = 1'b1;
      axi_r_valid_i = 1'b1; axi_r_data_i = 32'h5555_AAAA;
      tick();
      chk("rst_mid_req_ready", req_ready_o, 1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_o) pulses++;
         tick();
      end
      chk("rst_mid_no_rsp", pulses, 0);
      axi_r_valid_i = 1'b0;

      // slave never accepts the read address
      issue(1'b0, 32'h8000_0100, 32'd0, 4'd0);
      tick();                                   // cycle N+1
      req_valid_i = 1'b0;
      first_rsp = 0; first_err = 1'b0; first_rdata = 32'hFFFF_FFFF;
      for (int i = 1; i <= 300; i++) begin
         if (rsp_valid_o && first_rsp == 0) begin
            first_rsp   = i;
            first_err   = rsp_err_o;
            first_rdata = rsp_rdata_o;
         end
         tick();
      end
`ifdef YSYX_23060077_AXI_TIMEOUT_EN
      chk("tmo_rsp_cycle", first_rsp, 257);
      chk("tmo_rsp_err", first_err, 1);
      chk("tmo_rsp_rdata", first_rdata, 0);
      chk("tmo_ar_dropped", axi_ar_valid_o, 0);
`else
      chk("notmo_no_rsp", first_rsp, 0);
      chk("notmo_ar_held", axi_ar_valid_o, 1);
      chk("notmo_busy", req_ready_o, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
